seq_array_multiplier: RTL

- Parametrised, multi-cycle shift-and-add multiplier.
- Successor to the fixed 4x4 combinational array multiplier: operand width is generic, signed/unsigned mode is selectable per operation, and a start/busy/done handshake replaces the purely combinational path.
- Sits behind the tile's input pins: operands are captured on start, and the full-width product is held in a register until the next result.

---
 rtl/seq_array_multiplier.sv | 121 ++++++++++++
 1 files changed

// File: rtl/seq_array_multiplier.sv
// rtl/seq_array_multiplier.sv - multi-cycle shift-and-add signed/unsigned multiplier
//
// Purpose: multiplies two WIDTH-bit operands, one multiplier bit per clock.
// Operands are captured when start is seen in IDLE. The 2*WIDTH-bit product
// is registered and held until the next completion.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   start        request a multiply (sampled only in IDLE)
//   signed_mode  1 = two's complement operands, 0 = unsigned (sampled with start)
//   a, b         multiplicand / multiplier (sampled with start)
//   busy         high whenever the FSM is not IDLE
//   done         one-cycle pulse in the cycle after product is updated
//   product      registered 2*WIDTH-bit result
module seq_array_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    ONE_C = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [PW-1:0]    ONE_P = PW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [PW-1:0]    acc;     // running partial-product sum
  logic [PW-1:0]    mcand;   // |a| shifted left by the current bit index
  logic [WIDTH-1:0] mplier;  // |b|, shifted right so bit 0 is the current bit
  logic [CW-1:0]    cnt;     // index of the multiplier bit being processed
  logic             neg;     // result must be negated at the end

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    addend, acc_sum, acc_final;

  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  assign a_neg = signed_mode & a[WIDTH-1];
  assign b_neg = signed_mode & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + ONE_W) : a;
  assign b_mag = b_neg ? (~b + ONE_W) : b;

  assign addend    = mplier[0] ? mcand : '0;
  assign acc_sum   = acc + addend;
  // Final sum includes the last bit's contribution, then applies the sign.
  assign acc_final = neg ? (~acc_sum + ONE_P) : acc_sum;

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            cnt    <= '0;
            neg    <= a_neg ^ b_neg;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + ONE_C;
          if (cnt == LAST) begin
            product <= acc_final;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
